// File: rtl/lsu_bus_pkg.sv
// lsu_bus_pkg
// Shared types for the LSU data-bus bridge.
//   bus_state_e : bridge FSM state encoding (IDLE, WRITE, READ, RESP)
package lsu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } bus_state_e;

endpackage : lsu_bus_pkg

// File: rtl/lsu_wbuf.sv
// lsu_wbuf
// Synchronous store-buffer FIFO. Entry type is a type parameter so the top
// can pass its {addr, byte_en, data} struct straight through.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset (buffer empties on reset)
//   i_push, i_data : enqueue; ignored while o_full
//   i_pop          : dequeue head; ignored while o_empty
//   o_data         : head entry (valid while !o_empty)
//   o_full/o_empty : flags derived from the registered pointers
module lsu_wbuf
#(
    parameter int  DEPTH = 2,
    parameter type T     = logic [7:0]
)
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_data,
    output logic o_full,
    output logic o_empty
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    // Pointers carry one extra wrap bit: equal pointers mean empty, equal
    // index with differing wrap bit means full.
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    T              mem_q [DEPTH];
    T              mem_d [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
    assign o_data  = mem_q[rd_ptr_q[IW-1:0]];

    // Push is judged on the registered full flag, so a push while full is
    // dropped even if the head pops in the same cycle.
    assign push_ok = i_push & ~o_full;
    assign pop_ok  = i_pop  & ~o_empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[IW-1:0]] = i_data;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule : lsu_wbuf

// File: rtl/lsu_bus_bridge.sv
// lsu_bus_bridge
// Bridges the LSU load port (level request, ack-terminated) and store port
// (one-cycle pulse per store) onto a single-master Wishbone-classic-style
// data bus. Stores are buffered and always drain before a load is issued.
// Ports:
//   i_clk, i_rst_n                     : clock, async active-low reset
//   i_lsu_read, i_r_lsu_addr           : load request / address
//   o_r_lsu_data, o_lsu_ack            : load data, one-cycle completion
//   i_lsu_write, i_w_lsu_*             : store pulse, address, byte en, data
//   o_wbuf_full, o_wbuf_ovf            : buffer full, sticky overflow
//   o_bus_cyc/stb/we/addr/sel/wdata    : registered bus request
//   i_bus_rdata, i_bus_ack             : bus response
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transfer; buffered store first, else pending load
// WRITE | store buffer head on the bus, waiting for ack
// READ  | load on the bus, waiting for ack
// RESP  | o_lsu_ack pulse with registered read data
module lsu_bus_bridge
    import lsu_bus_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int WBUF_DEPTH = 2
)
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_lsu_read,
    input  logic [AW-1:0]   i_r_lsu_addr,
    output logic [DW-1:0]   o_r_lsu_data,
    output logic            o_lsu_ack,
    input  logic            i_lsu_write,
    input  logic [AW-1:0]   i_w_lsu_addr,
    input  logic [DW/8-1:0] i_w_lsu_byte_en,
    input  logic [DW-1:0]   i_w_lsu_data,
    output logic            o_wbuf_full,
    output logic            o_wbuf_ovf,
    output logic            o_bus_cyc,
    output logic            o_bus_stb,
    output logic            o_bus_we,
    output logic [AW-1:0]   o_bus_addr,
    output logic [DW/8-1:0] o_bus_sel,
    output logic [DW-1:0]   o_bus_wdata,
    input  logic [DW-1:0]   i_bus_rdata,
    input  logic            i_bus_ack
);

    localparam int BW = DW / 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [BW-1:0] be;
        logic [DW-1:0] data;
    } wbuf_entry_t;

    bus_state_e    state_q, state_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [BW-1:0] sel_q, sel_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          ack_q, ack_d;
    logic          ovf_q, ovf_d;

    wbuf_entry_t   wbuf_in;
    wbuf_entry_t   wbuf_head;
    logic          wbuf_pop;
    logic          wbuf_full;
    logic          wbuf_empty;

    assign wbuf_in = '{addr: i_w_lsu_addr, be: i_w_lsu_byte_en, data: i_w_lsu_data};

    lsu_wbuf #(
        .DEPTH (WBUF_DEPTH),
        .T     (wbuf_entry_t)
    ) u_wbuf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_lsu_write),
        .i_data  (wbuf_in),
        .i_pop   (wbuf_pop),
        .o_data  (wbuf_head),
        .o_full  (wbuf_full),
        .o_empty (wbuf_empty)
    );

    assign ovf_d = ovf_q | (i_lsu_write & wbuf_full);

    // Bus request fields are only loaded on leaving IDLE, so they stay
    // stable for the whole strobe. Every completion returns through IDLE,
    // which guarantees a low-strobe cycle between transfers.
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        we_d     = we_q;
        addr_d   = addr_q;
        sel_d    = sel_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        ack_d    = 1'b0;
        wbuf_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!wbuf_empty) begin
                    state_d = WRITE;
                    cyc_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = wbuf_head.addr;
                    sel_d   = wbuf_head.be;
                    wdata_d = wbuf_head.data;
                end else if (i_lsu_read) begin
                    state_d = READ;
                    cyc_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = i_r_lsu_addr;
                    sel_d   = '1;
                end
            end
            WRITE: begin
                if (i_bus_ack) begin
                    wbuf_pop = 1'b1;
                    cyc_d    = 1'b0;
                    state_d  = IDLE;
                end
            end
            READ: begin
                if (i_bus_ack) begin
                    rdata_d = i_bus_rdata;
                    ack_d   = 1'b1;
                    cyc_d   = 1'b0;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_bus_cyc    = cyc_q;
    assign o_bus_stb    = cyc_q;
    assign o_bus_we     = we_q;
    assign o_bus_addr   = addr_q;
    assign o_bus_sel    = sel_q;
    assign o_bus_wdata  = wdata_q;
    assign o_r_lsu_data = rdata_q;
    assign o_lsu_ack    = ack_q;
    assign o_wbuf_full  = wbuf_full;
    assign o_wbuf_ovf   = ovf_q;

endmodule : lsu_bus_bridge

// File: tb/tb_lsu_bus_bridge.sv
// tb_lsu_bus_bridge
// Directed bench for lsu_bus_bridge with a transaction-level reference
// model (expected-store queue, occupancy count, sticky overflow, pending
// load response) checked every cycle, plus literal cycle-exact checks.
module tb_lsu_bus_bridge;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          lsu_read = 1'b0;
    logic [AW-1:0] r_addr = '0;
    logic [DW-1:0] r_data;
    logic          lsu_ack;
    logic          lsu_write = 1'b0;
    logic [AW-1:0] w_addr = '0;
    logic [BW-1:0] w_be = '0;
    logic [DW-1:0] w_data = '0;
    logic          wbuf_full;
    logic          wbuf_ovf;
    logic          bus_cyc;
    logic          bus_stb;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [BW-1:0] bus_sel;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata = '0;
    logic          bus_ack = 1'b0;

    always #5 clk = ~clk;

    lsu_bus_bridge #(.AW(AW), .DW(DW), .WBUF_DEPTH(DEPTH)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_lsu_read      (lsu_read),
        .i_r_lsu_addr    (r_addr),
        .o_r_lsu_data    (r_data),
        .o_lsu_ack       (lsu_ack),
        .i_lsu_write     (lsu_write),
        .i_w_lsu_addr    (w_addr),
        .i_w_lsu_byte_en (w_be),
        .i_w_lsu_data    (w_data),
        .o_wbuf_full     (wbuf_full),
        .o_wbuf_ovf      (wbuf_ovf),
        .o_bus_cyc       (bus_cyc),
        .o_bus_stb       (bus_stb),
        .o_bus_we        (bus_we),
        .o_bus_addr      (bus_addr),
        .o_bus_sel       (bus_sel),
        .o_bus_wdata     (bus_wdata),
        .i_bus_rdata     (bus_rdata),
        .i_bus_ack       (bus_ack)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Slave: acks after wait_cfg wait states; while stb is low it drives
    // spur_ack so stray acks can be injected. Junk data outside ack cycles.
    int            wait_cfg = 0;
    int            w_cnt = 0;
    logic          spur_ack = 1'b0;
    logic [DW-1:0] slave_rdata = '0;

    always @(posedge clk) begin
        #1;
        if (bus_stb) begin
            if (w_cnt >= wait_cfg) begin
                bus_ack   = 1'b1;
                bus_rdata = slave_rdata;
                w_cnt     = 0;
            end else begin
                bus_ack   = 1'b0;
                bus_rdata = 32'hBAD0_0000;
                w_cnt++;
            end
        end else begin
            bus_ack   = spur_ack;
            bus_rdata = 32'hBAD0_0000;
            w_cnt     = 0;
        end
    end

    // Reference model
    typedef struct {
        logic [AW-1:0] a;
        logic [BW-1:0] s;
        logic [DW-1:0] d;
    } st_t;

    st_t           exp_q[$];
    int            m_count = 0;
    logic          m_ovf = 1'b0;
    logic          m_ack_next = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    int            n_writes = 0;
    int            n_reads = 0;
    logic          p_stb = 1'b0;
    logic          p_ack = 1'b0;
    logic          p_we = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [BW-1:0] p_sel = '0;
    logic [DW-1:0] p_wdata = '0;

    always @(negedge clk) begin
        int   cnt0;
        st_t  e;
        if (!rst_n) begin
            exp_q.delete();
            m_count    = 0;
            m_ovf      = 1'b0;
            m_ack_next = 1'b0;
            m_rdata    = '0;
            p_stb      = 1'b0;
            p_ack      = 1'b0;
            chk("rst_stb", bus_stb, 0);
            chk("rst_cyc", bus_cyc, 0);
            chk("rst_lsu_ack", lsu_ack, 0);
            chk("rst_full", wbuf_full, 0);
            chk("rst_ovf", wbuf_ovf, 0);
            chk("rst_rdata", r_data, 0);
            chk("rst_addr", bus_addr, 0);
        end else begin
            cnt0 = m_count;
            chk("cyc_eq_stb", bus_cyc, bus_stb);
            chk("wbuf_full", wbuf_full, (m_count == DEPTH));
            chk("wbuf_ovf", wbuf_ovf, m_ovf);
            chk("lsu_ack", lsu_ack, m_ack_next);
            chk("lsu_rdata", r_data, m_rdata);
            if (p_stb && !p_ack) begin
                chk("stb_held", bus_stb, 1);
                chk("addr_stable", bus_addr, p_addr);
                chk("we_stable", bus_we, p_we);
                chk("sel_stable", bus_sel, p_sel);
                chk("wdata_stable", bus_wdata, p_wdata);
            end
            if (p_stb && p_ack)
                chk("idle_gap", bus_stb, 0);
            m_ack_next = 1'b0;
            if (bus_stb && bus_ack) begin
                if (bus_we) begin
                    n_writes++;
                    chk("write_expected", (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("wr_addr", bus_addr, e.a);
                        chk("wr_sel", bus_sel, e.s);
                        chk("wr_data", bus_wdata, e.d);
                        m_count--;
                    end
                end else begin
                    n_reads++;
                    chk("read_after_drain", exp_q.size(), 0);
                    chk("read_requested", lsu_read, 1);
                    chk("rd_addr", bus_addr, r_addr);
                    chk("rd_sel", bus_sel, {BW{1'b1}});
                    m_ack_next = 1'b1;
                    m_rdata    = bus_rdata;
                end
            end
            if (lsu_write) begin
                if (cnt0 == DEPTH) begin
                    m_ovf = 1'b1;
                end else begin
                    e.a = w_addr;
                    e.s = w_be;
                    e.d = w_data;
                    exp_q.push_back(e);
                    m_count++;
                end
            end
            p_stb   = bus_stb;
            p_ack   = bus_ack;
            p_we    = bus_we;
            p_addr  = bus_addr;
            p_sel   = bus_sel;
            p_wdata = bus_wdata;
        end
    end

    task automatic start_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [AW-1:0] a, input logic [BW-1:0] s, input logic [DW-1:0] d);
        lsu_write = 1'b1;
        w_addr    = a;
        w_be      = s;
        w_data    = d;
    endtask

    initial begin
        int wr0;
        int rd0;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_stb", bus_stb, 0);
        chk("reset_we", bus_we, 0);
        chk("reset_sel", bus_sel, 0);
        chk("reset_wdata", bus_wdata, 0);
        chk("reset_full", wbuf_full, 0);
        start_cycle();
        rst_n = 1'b1;
        start_cycle();

        // 1: single load, zero-wait slave
        wait_cfg    = 0;
        slave_rdata = 32'hDEADBEEF;
        start_cycle();
        lsu_read = 1'b1;
        r_addr   = 32'h100;
        @(negedge clk);
        chk("t1_stb_c0", bus_stb, 0);
        @(negedge clk);
        chk("t1_stb_c1", bus_stb, 1);
        chk("t1_we_c1", bus_we, 0);
        chk("t1_addr_c1", bus_addr, 32'h100);
        chk("t1_lsu_ack_c1", lsu_ack, 0);
        @(negedge clk);
        chk("t1_lsu_ack_c2", lsu_ack, 1);
        chk("t1_rdata_c2", r_data, 32'hDEADBEEF);
        start_cycle();
        lsu_read = 1'b0;
        @(negedge clk);
        chk("t1_lsu_ack_c3", lsu_ack, 0);
        chk("t1_rdata_hold", r_data, 32'hDEADBEEF);
        repeat (2) start_cycle();

        // 2: store then load one cycle later; write must complete first
        slave_rdata = 32'hCAFE0001;
        start_cycle();
        store(32'h200, 4'b0011, 32'h1234);
        start_cycle();
        lsu_write = 1'b0;
        lsu_read  = 1'b1;
        r_addr    = 32'h200;
        @(negedge clk);
        chk("t2_stb_c1", bus_stb, 0);
        @(negedge clk);
        chk("t2_stb_c2", bus_stb, 1);
        chk("t2_we_c2", bus_we, 1);
        chk("t2_sel_c2", bus_sel, 4'b0011);
        chk("t2_addr_c2", bus_addr, 32'h200);
        chk("t2_wdata_c2", bus_wdata, 32'h1234);
        @(negedge clk);
        chk("t2_stb_c3", bus_stb, 0);
        @(negedge clk);
        chk("t2_stb_c4", bus_stb, 1);
        chk("t2_we_c4", bus_we, 0);
        chk("t2_sel_c4", bus_sel, 4'b1111);
        @(negedge clk);
        chk("t2_lsu_ack_c5", lsu_ack, 1);
        chk("t2_rdata_c5", r_data, 32'hCAFE0001);
        start_cycle();
        lsu_read = 1'b0;
        repeat (2) start_cycle();

        // 3+4: two stores, 3 wait states, extra stores while full
        wait_cfg = 3;
        wr0      = n_writes;
        start_cycle();
        store(32'h400, 4'b1111, 32'hA0A0A0A0);
        start_cycle();
        store(32'h404, 4'b1100, 32'hB1B1B1B1);
        @(negedge clk);
        chk("t3_full_c1", wbuf_full, 0);
        start_cycle();
        lsu_write = 1'b0;
        @(negedge clk);
        chk("t3_full_c2", wbuf_full, 1);
        chk("t3_stb_c2", bus_stb, 1);
        chk("t3_wdata_c2", bus_wdata, 32'hA0A0A0A0);
        start_cycle();
        store(32'h408, 4'b1111, 32'hC2C2C2C2);
        @(negedge clk);
        chk("t4_ovf_c3", wbuf_ovf, 0);
        start_cycle();
        lsu_write = 1'b0;
        @(negedge clk);
        chk("t4_ovf_c4", wbuf_ovf, 1);
        start_cycle();
        store(32'h40C, 4'b1111, 32'hD3D3D3D3);
        @(negedge clk);
        chk("t4_ack_c5", bus_ack, 1);
        chk("t4_full_c5", wbuf_full, 1);
        start_cycle();
        lsu_write = 1'b0;
        @(negedge clk);
        chk("t3_full_c6", wbuf_full, 0);
        chk("t4_ovf_c6", wbuf_ovf, 1);
        repeat (8) @(negedge clk);
        chk("t4_two_writes", n_writes - wr0, 2);
        chk("t4_ovf_sticky", wbuf_ovf, 1);
        chk("t4_full_end", wbuf_full, 0);

        // 5: reset during a READ wait state
        wait_cfg    = 5;
        slave_rdata = 32'h0BADF00D;
        start_cycle();
        lsu_read = 1'b1;
        r_addr   = 32'h300;
        @(negedge clk);
        @(negedge clk);
        chk("t5_stb_c1", bus_stb, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_cyc_async", bus_cyc, 0);
        chk("t5_stb_async", bus_stb, 0);
        lsu_read = 1'b0;
        @(negedge clk);
        start_cycle();
        rst_n = 1'b1;
        rd0   = n_reads;
        wr0   = n_writes;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t5_no_ack", lsu_ack, 0);
            chk("t5_no_stb", bus_stb, 0);
        end
        chk("t5_ovf_cleared", wbuf_ovf, 0);
        chk("t5_no_read", n_reads - rd0, 0);
        chk("t5_no_write", n_writes - wr0, 0);

        // 6: stray acks while stb low must not pop or complete anything
        wait_cfg = 1;
        wr0      = n_writes;
        @(negedge clk);
        spur_ack = 1'b1;
        start_cycle();
        store(32'h500, 4'b0001, 32'h55);
        @(negedge clk);
        chk("t6_stb_c0", bus_stb, 0);
        start_cycle();
        store(32'h504, 4'b0010, 32'h6600);
        @(negedge clk);
        chk("t6_spur_ack_c1", bus_ack, 1);
        chk("t6_stb_c1", bus_stb, 0);
        spur_ack = 1'b0;
        start_cycle();
        lsu_write = 1'b0;
        @(negedge clk);
        chk("t6_full_c2", wbuf_full, 1);
        chk("t6_stb_c2", bus_stb, 1);
        chk("t6_wdata_c2", bus_wdata, 32'h55);
        repeat (10) @(negedge clk);
        chk("t6_two_writes", n_writes - wr0, 2);
        chk("t6_full_end", wbuf_full, 0);
        chk("t6_no_read", lsu_ack, 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_lsu_bus_bridge
